// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data ports share one request bus,
// with alternating priority on conflicts and a per-transaction acknowledge timeout.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_ack_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    dm_ack_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ack_i,
    output logic                    err_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    state_t                  state_q;
    logic                    last_gnt_q;   // 0 = fetch granted last, 1 = data
    logic [CNT_W-1:0]        cnt_q;
    logic                    mem_req_q, mem_we_q;
    logic [BE_W-1:0]         mem_be_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q, dm_rdata_q;
    logic                    if_ack_q, dm_ack_q, err_q;

    logic pick_i, pick_d;

    // On conflict, fetch wins only if data was granted at the previous conflict.
    assign pick_i = if_req_i && (!dm_req_i || last_gnt_q);
    assign pick_d = dm_req_i && !pick_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_i) begin
                        state_q     <= GNT_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '1;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        cnt_q       <= '0;
                    end else if (pick_d) begin
                        state_q     <= GNT_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_be_q    <= dm_be_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        cnt_q       <= '0;
                    end
                    if (if_req_i && dm_req_i) begin
                        last_gnt_q <= pick_d;
                    end
                end
                GNT_I, GNT_D: begin
                    // An ack arriving on the expiry cycle still counts as a normal completion.
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (state_q == GNT_I) begin
                            if_rdata_q <= mem_rdata_i;
                            if_ack_q   <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata_i;
                            end
                            dm_ack_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        err_q     <= 1'b1;
                        if (state_q == GNT_I) begin
                            if_rdata_q <= '0;
                            if_ack_q   <= 1'b1;
                        end else begin
                            dm_rdata_q <= '0;
                            dm_ack_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
endmodule
